// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite control unit: a FETCH/DECODE/EXEC/MEM/WB sequencer that
// drives datapath strobes and mux selects and counts retired instructions.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        reg_we,
  output logic        mem_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        ext_op,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] retired_q, retired_d;

  logic [5:0] op, funct;
  logic is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
  logic is_illegal;

  logic       ir_we_c, pc_we_c, reg_we_c, mem_we_c;
  logic [1:0] alu_op_dec;
  logic       alu_src_dec, ext_op_dec;

  // Only opcode and funct take part in decoding; the operand fields are datapath-only.
  logic unused_fields;
  assign unused_fields = ^instr[25:6];

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  assign is_addu = (op == 6'b000000) && (funct == 6'b100001);
  assign is_subu = (op == 6'b000000) && (funct == 6'b100011);
  assign is_jr   = (op == 6'b000000) && (funct == 6'b001000);
  assign is_ori  = (op == 6'b001101);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_lui  = (op == 6'b001111);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);
  assign is_illegal = !(is_addu | is_subu | is_jr | is_ori | is_lw | is_sw |
                        is_beq | is_lui | is_j | is_jal);

  // ALU controls decoded once; they are presented unchanged through EXEC, MEM and WB.
  always_comb begin
    alu_op_dec  = 2'd0;
    alu_src_dec = 1'b0;
    ext_op_dec  = 1'b0;
    if (is_subu) begin
      alu_op_dec = 2'd1;
    end else if (is_ori) begin
      alu_op_dec  = 2'd2;
      alu_src_dec = 1'b1;
    end else if (is_lui) begin
      alu_op_dec  = 2'd3;
      alu_src_dec = 1'b1;
    end else if (is_lw || is_sw) begin
      alu_src_dec = 1'b1;
      ext_op_dec  = 1'b1;
    end else if (is_beq) begin
      alu_op_dec = 2'd1;
      ext_op_dec = 1'b1;
    end
  end

  always_comb begin
    state_d  = S_FETCH;
    ir_we_c  = 1'b0;
    pc_we_c  = 1'b0;
    reg_we_c = 1'b0;
    mem_we_c = 1'b0;
    npc_sel  = 2'd0;
    reg_dst  = 2'd0;
    wd_sel   = 2'd0;
    alu_op   = 2'd0;
    alu_src  = 1'b0;
    ext_op   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we_c = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j) begin
          pc_we_c = 1'b1;
          npc_sel = 2'd2;
        end else if (is_jal) begin
          pc_we_c  = 1'b1;
          npc_sel  = 2'd2;
          reg_we_c = 1'b1;
          reg_dst  = 2'd2;
          wd_sel   = 2'd2;
        end else if (is_jr) begin
          pc_we_c = 1'b1;
          npc_sel = 2'd3;
        end else if (is_illegal) begin
          pc_we_c = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = alu_op_dec;
        alu_src = alu_src_dec;
        ext_op  = ext_op_dec;
        if (is_beq) begin
          pc_we_c = 1'b1;
          npc_sel = zero ? 2'd1 : 2'd0;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_addu || is_subu || is_ori || is_lui) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op  = alu_op_dec;
        alu_src = alu_src_dec;
        ext_op  = ext_op_dec;
        if (is_sw) begin
          mem_we_c = 1'b1;
          pc_we_c  = 1'b1;
        end else if (is_lw) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        alu_op   = alu_op_dec;
        alu_src  = alu_src_dec;
        ext_op   = ext_op_dec;
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        reg_dst  = (is_addu || is_subu) ? 2'd1 : 2'd0;
        wd_sel   = is_lw ? 2'd1 : 2'd0;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks strobes combinationally so an abort takes effect before the next edge.
  assign ir_we  = ir_we_c  & ~reset;
  assign pc_we  = pc_we_c  & ~reset;
  assign reg_we = reg_we_c & ~reset;
  assign mem_we = mem_we_c & ~reset;

  assign retired_d = pc_we ? (retired_q + 32'd1) : retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
